// File: rtl/down_timer_pkg.sv
// Shared types and default constants for the down_timer block.
package down_timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultWidth       = 8;
    localparam int unsigned DefaultPrescaleDiv = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Divides a stream of enabled cycles into one tick every DIV enables.
// Used by down_timer only when DOWN_TIMER_PRESCALE_EN is defined.
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Tick on the enable that completes a group of DIV.
    assign tick = enable && (cnt_q == CntW'(DIV - 1));

    // Next phase: clear restarts the group, otherwise advance on each enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot or periodic reload.
// Optional prescaler enabled by defining DOWN_TIMER_PRESCALE_EN.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH        = DefaultWidth,
    parameter int unsigned PRESCALE_DIV = DefaultPrescaleDiv
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             periodic,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             tc_pulse,
    output logic             busy
);

    if (PRESCALE_DIV < 1) begin : g_bad_div
        $error("PRESCALE_DIV must be at least 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
    // Prescaler only advances on enabled cycles while running; load restarts its phase.
    tick_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (load),
        .enable (enable && (state_q == StRun)),
        .tick   (tick)
    );
`else
    assign tick = enable;
`endif

    // Next-state: load beats counting; terminal count at out==1 stops or reloads.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            out_d    = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? StRun : StDone;
        end else if ((state_q == StRun) && tick) begin
            if (out_q > WIDTH'(1)) begin
                out_d = out_q - 1'b1;
            end else if (out_q == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (periodic) begin
                    out_d = reload_q;
                end else begin
                    out_d   = '0;
                    state_d = StDone;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            out_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign out      = out_q;
    assign zero     = (out_q == '0);
    assign tc_pulse = tc_q;
    assign busy     = (state_q == StRun);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: a count-based reference model plus
// directed vectors with hand-computed expectations.
module tb_down_timer;

`ifdef DOWN_TIMER_PRESCALE_EN
    localparam int PDIV = 4;
`else
    localparam int PDIV = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic       enable = 1'b0;
    logic       periodic = 1'b0;
    logic [7:0] out;
    logic       zero;
    logic       tc_pulse;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    down_timer #(
        .WIDTH        (8),
        .PRESCALE_DIV (PDIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .periodic   (periodic),
        .out        (out),
        .zero       (zero),
        .tc_pulse   (tc_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: period length, effective ticks and enables since the last load.
    bit m_run;
    int m_len;
    int m_n;
    int m_e;
    bit m_tc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 1'b0; m_len = 0; m_n = 0; m_e = 0; m_tc = 1'b0;
        end else begin
            m_tc = 1'b0;
            if (load) begin
                m_len = int'(load_value);
                m_n   = 0;
                m_e   = 0;
                m_run = (load_value != 8'd0);
            end else if (m_run && enable) begin
                m_e++;
                if (m_e % PDIV == 0) begin
                    m_n++;
                    if (m_n % m_len == 0) begin
                        m_tc = 1'b1;
                        if (!periodic) m_run = 1'b0;
                    end
                end
            end
        end
    end

    function automatic int model_out();
        return m_run ? (m_len - (m_n % m_len)) : 0;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out", int'(out), model_out());
            chk("model_zero", int'(zero), int'(model_out() == 0));
            chk("model_tc", int'(tc_pulse), int'(m_tc));
            chk("model_busy", int'(busy), int'(m_run));
        end
    end

    // Apply inputs for the next edge, then return just after that edge.
    task automatic cyc(input bit ld, input int lv, input bit en, input bit per);
        load       = ld;
        load_value = 8'(lv);
        enable     = en;
        periodic   = per;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tc", int'(tc_pulse), 0);
        reset  = 1'b0;
        chk_en = 1'b1;
        cyc(0, 0, 1, 0);
        chk("idle_hold", int'(out), 0);

`ifndef DOWN_TIMER_PRESCALE_EN
        begin
            int exp_os[4]  = '{3, 2, 1, 0};
            int exp_per[12] = '{3, 2, 1, 4, 3, 2, 1, 4, 3, 2, 1, 4};
            int exp_gap[4] = '{5, 4, 4, 3};
            bit en_gap[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};

            // One-shot from 3.
            for (int i = 0; i < 4; i++) begin
                cyc(i == 0, 3, 1, 0);
                chk("os_out", int'(out), exp_os[i]);
                chk("os_tc", int'(tc_pulse), int'(i == 3));
            end
            chk("os_busy", int'(busy), 0);
            repeat (10) cyc(0, 0, 1, 0);
            chk("os_stay0", int'(out), 0);

            // Periodic from 4.
            cyc(1, 4, 1, 1);
            chk("per_load", int'(out), 4);
            for (int i = 0; i < 12; i++) begin
                cyc(0, 0, 1, 1);
                chk("per_out", int'(out), exp_per[i]);
                chk("per_tc", int'(tc_pulse), int'(exp_per[i] == 4));
                chk("per_busy", int'(busy), 1);
            end

            // Enable gaps from 5.
            for (int i = 0; i < 4; i++) begin
                cyc(i == 0, 5, en_gap[i], 0);
                chk("gap_out", int'(out), exp_gap[i]);
            end
            cyc(0, 0, 1, 0);
            cyc(0, 0, 1, 0);
            chk("pre_ld_one", int'(out), 1);
            cyc(1, 9, 1, 0);
            chk("ld_prio_out", int'(out), 9);
            chk("ld_prio_tc", int'(tc_pulse), 0);

            // Load of zero.
            cyc(1, 0, 1, 1);
            chk("z_busy", int'(busy), 0);
            chk("z_zero", int'(zero), 1);
            chk("z_tc", int'(tc_pulse), 0);
            repeat (4) cyc(0, 0, 1, 1);

            // Full-scale count.
            cyc(1, 255, 1, 0);
            chk("max_load", int'(out), 255);
            repeat (254) cyc(0, 0, 1, 0);
            chk("max_one", int'(out), 1);
            cyc(0, 0, 1, 0);
            chk("max_zero", int'(out), 0);
            chk("max_tc", int'(tc_pulse), 1);
            cyc(0, 0, 1, 0);
            chk("max_nowrap", int'(out), 0);

            // Asynchronous reset mid-count.
            cyc(1, 8, 1, 0);
            repeat (3) cyc(0, 0, 1, 0);
            chk("pre_rst_out", int'(out), 5);
            #2 reset = 1'b1;
            #1;
            chk("arst_out", int'(out), 0);
            chk("arst_busy", int'(busy), 0);
            chk("arst_zero", int'(zero), 1);
            chk("arst_tc", int'(tc_pulse), 0);
            #3 reset = 1'b0;
            @(posedge clk);
            #1;
            cyc(0, 0, 1, 0);
            chk("post_rst_idle", int'(out), 0);
        end
`else
        // Prescaled: load 2, decrement every 4 enables, terminal on the 8th.
        cyc(1, 2, 1, 0);
        chk("ps_load", int'(out), 2);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1, 0);
            chk("ps_out", int'(out), (i < 4) ? 2 : ((i < 8) ? 1 : 0));
            chk("ps_tc", int'(tc_pulse), int'(i == 8));
        end
        // Reload mid-interval restarts the prescale phase.
        cyc(1, 3, 1, 0);
        repeat (2) cyc(0, 0, 1, 0);
        cyc(1, 3, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        chk("ps_restart_hold", int'(out), 3);
        cyc(0, 0, 1, 0);
        chk("ps_restart_dec", int'(out), 2);
`endif

        repeat (2) cyc(0, 0, 0, 0);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
